// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit holding the HI/LO registers.
// Radix-2 shift-add multiply, restoring shift-subtract divide, one bit per
// cycle. MULT/DIV use sign-magnitude with a sign fix-up in the FIX state.
// Optional feature macro: CPU_MDU_EARLY_TERM_EN (multiply ends as soon as the
// remaining multiplier bits are all zero; divide is unaffected).
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW    = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               op_mul;
    logic               neg_res;
    logic               neg_rem;

    // Multiply datapath: product accumulator, left-shifting multiplicand,
    // right-shifting multiplier.
    logic [DW-1:0]      acc;
    logic [DW-1:0]      mcand;
    logic [WIDTH-1:0]   mplr;

    // Divide datapath: partial remainder, dividend/quotient shift register,
    // divisor magnitude.
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvsr;

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [DW-1:0]      mul_sum;
    logic               mul_last;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [DW-1:0]      prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes and signs for the signed ops, taken at acceptance.
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? (-a) : a;
        b_mag     = b_neg ? (-b) : b;
    end

    // One iteration of shift-add and restoring shift-subtract, plus fix-up.
    always_comb begin
        mul_sum      = acc + (mplr[0] ? mcand : '0);
        div_shift    = {rem, quo[WIDTH-1]};
        div_diff     = div_shift - {1'b0, dvsr};
        div_ge       = (div_shift >= {1'b0, dvsr});
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        prod_fix     = neg_res ? (-acc) : acc;
        quo_fix      = neg_res ? (-quo) : quo;
        rem_fix      = neg_rem ? (-rem) : rem;
`ifdef CPU_MDU_EARLY_TERM_EN
        // Stop once the multiplier bits not yet consumed are all zero.
        mul_last     = (counter == '0) || ((mplr >> 1) == '0);
`else
        mul_last     = (counter == '0);
`endif
    end

    // Control FSM, datapath iteration and HI/LO update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            op_mul  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state   <= S_MUL;
                                busy    <= 1'b1;
                                counter <= CNT_W'(WIDTH - 1);
                                op_mul  <= 1'b1;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= 1'b0;
                                acc     <= '0;
                                mcand   <= DW'(a_mag);
                                mplr    <= b_mag;
                            end
                            OP_DIV, OP_DIVU: begin
                                state   <= S_DIV;
                                busy    <= 1'b1;
                                counter <= CNT_W'(WIDTH - 1);
                                op_mul  <= 1'b0;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= a_neg;
                                rem     <= '0;
                                quo     <= a_mag;
                                dvsr    <= b_mag;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc     <= mul_sum;
                        mcand   <= mcand << 1;
                        mplr    <= mplr >> 1;
                        counter <= counter - CNT_W'(1);
                        if (mul_last) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_DIV: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem     <= div_rem_next;
                        quo     <= {quo[WIDTH-2:0], div_ge};
                        counter <= counter - CNT_W'(1);
                        if (counter == '0) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        done <= 1'b1;
                        if (op_mul) begin
                            {hi, lo} <= prod_fix;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of mul_div_unit with hand-computed results.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;
    int lat;
    int bad;
    int exp_lat;
    int seen_done;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; returns 1ns after that edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd7;
    endtask

    // Wait (bounded) for done; counts edges from acceptance and any cycle
    // before done where busy dropped or hi/lo moved.
    task automatic wait_done(output int l, output int nbad);
        logic [31:0] h0;
        logic [31:0] l0;
        h0   = hi;
        l0   = lo;
        l    = 0;
        nbad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                l = i;
                break;
            end
            if (busy !== 1'b1 || hi !== h0 || lo !== l0) nbad++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 3'd7;
        a      = '0;
        b      = '0;
        abort  = 1'b0;
        #2;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // MULTU max*max, full 33-cycle latency
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_e0", busy, 1'b1);
        wait_done(lat, bad);
        check("multu_latency", 64'(lat), 64'd33);
        check("multu_busy_iter", 64'(bad), 64'd0);
        check("multu_busy_at_done", busy, 1'b0);
        check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // MULT -3*7 issued in the done cycle (back-to-back)
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        check("mult_done_pulse_end", done, 1'b0);
        check("mult_busy_e0", busy, 1'b1);
        wait_done(lat, bad);
        check("mult_iter", 64'(bad), 64'd0);
        check("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // MULT -2*-3 = 6
        issue(3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        wait_done(lat, bad);
        check("mult_negneg_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

        // DIV -7/2: q=-3 r=-1
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bad);
        check("div_latency", 64'(lat), 64'd33);
        check("div_iter", 64'(bad), 64'd0);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        // DIV 7/-2: q=-3 r=+1 (remainder follows dividend)
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, bad);
        check("div_negdvsr_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        // DIVU 0xFFFFFFF9/2 unsigned
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bad);
        check("divu_hilo", {hi, lo}, 64'h0000_0001_7FFF_FFFC);

        // DIVU by zero
        issue(3'd3, 32'd100, 32'd0);
        wait_done(lat, bad);
        check("divu_zero_latency", 64'(lat), 64'd33);
        check("divu_zero_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

        // DIV overflow case
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bad);
        check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        // MTHI then MTLO on consecutive edges
        @(posedge clk);
        #1;
        issue(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_hilo", {hi, lo}, 64'h1234_5678_8000_0000);
        check("mthi_busy_done", {busy, done}, 2'b00);
        issue(3'd5, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        check("mtlo_busy_done", {busy, done}, 2'b00);

        // Op 7 is a no-op
        issue(3'd7, 32'hDEAD_BEEF, 32'h1);
        @(posedge clk);
        #1;
        check("nop_busy", busy, 1'b0);
        check("nop_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // Abort in IDLE drops a same-cycle MTHI
        abort = 1'b1;
        issue(3'd4, 32'h5555_5555, 32'd0);
        abort = 1'b0;
        check("idle_abort_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // DIVU aborted at cycle 10
        issue(3'd3, 32'd1000, 32'd7);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
        end
        #1;
        check("abort_busy_before", busy, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy_after", busy, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_hilo_kept", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // MULTU 5*3 (early termination shortens latency when enabled)
        issue(3'd1, 32'd5, 32'd3);
        wait_done(lat, bad);
`ifdef CPU_MDU_EARLY_TERM_EN
        exp_lat = 3;
`else
        exp_lat = 33;
`endif
        check("multu_small_latency", 64'(lat), 64'(exp_lat));
        check("multu_small_hilo", {hi, lo}, 64'd15);

        // Async reset in the middle of a MULTU
        @(posedge clk);
        #1;
        issue(3'd1, 32'h0001_0001, 32'hFFFF_0000);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Unit is usable again after the reset
        issue(3'd5, 32'hCAFE_F00D, 32'd0);
        check("post_rst_mtlo", {hi, lo}, 64'h0000_0000_CAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
